// File: rtl/et_rd_port_sched_pkg.sv
// Shared definitions for the ET event-buffer read-port scheduler: FSM state codes,
// default geometry and a small round-robin helper.
package et_rd_port_sched_pkg;

  localparam int DEF_NEVENTS = 2048;
  localparam int DEF_AW      = 12;
  localparam int DEF_LW      = 13;
  localparam int DEF_NREQ    = 3;
  localparam int DEF_TW      = 2;
  localparam int DEF_RD_LAT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BURST = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  // Requester index that follows w in round-robin order.
  function automatic int rrNext(input int w, input int n);
    return (w + 1 >= n) ? 0 : w + 1;
  endfunction

endpackage

// File: rtl/et_rd_port_sched_arb.sv
// Combinational round-robin pick: the first requesting index at or after the pointer wins.
module et_rd_port_sched_arb
  import et_rd_port_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int TW   = DEF_TW
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [TW-1:0]   ptr_i,
  output logic            vld_o,
  output logic [TW-1:0]   idx_o
);

  int            cand;
  logic [TW-1:0] candIdx;

  always_comb begin
    vld_o   = 1'b0;
    idx_o   = '0;
    cand    = 0;
    candIdx = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      candIdx = TW'(cand);
      if (!vld_o && req_i[candIdx]) begin
        vld_o = 1'b1;
        idx_o = candIdx;
      end
    end
  end

endmodule

// File: rtl/et_rd_port_sched.sv
// Read-port scheduler for the ET event buffer: round-robin grants, one contiguous
// read burst per grant, and every read tagged with its owner RD_LAT cycles later.
module et_rd_port_sched
  import et_rd_port_sched_pkg::*;
#(
  parameter int NEVENTS = DEF_NEVENTS,
  parameter int AW      = DEF_AW,
  parameter int LW      = DEF_LW,
  parameter int NREQ    = DEF_NREQ,
  parameter int TW      = DEF_TW,
  parameter int RD_LAT  = DEF_RD_LAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_live,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*LW-1:0] req_len,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic               abort,
  output logic               busy,
  output logic               out_rena,
  output logic [AW-1:0]      out_raddr,
  output logic               rd_vld,
  output logic [TW-1:0]      rd_tag
);

  localparam logic [LW-1:0] MAX_LEN = LW'(2 * NEVENTS);

  state_e          state_q, state_d;
  logic [TW-1:0]   rr_q, rr_d;
  logic [TW-1:0]   owner_q, owner_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [LW-1:0]   rem_q, rem_d;
  logic            abort_q, abort_d;

  logic            pick_vld;
  logic [TW-1:0]   pick_idx;
  logic [AW-1:0]   sel_addr;
  logic [LW-1:0]   sel_len;
  logic [NREQ-1:0] owner_oh;

  logic [RD_LAT-1:0] vld_pipe_q;
  logic [TW-1:0]     tag_pipe_q [RD_LAT];

  et_rd_port_sched_arb #(
    .NREQ (NREQ),
    .TW   (TW)
  ) u_arb (
    .req_i (req),
    .ptr_i (rr_q),
    .vld_o (pick_vld),
    .idx_o (pick_idx)
  );

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == TW'(i)) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_len  = req_len[i*LW +: LW];
      end
    end
  end

  // A run-window drop always wins over normal progress, so a burst ending on the
  // same cycle reports abort and never done.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    abort_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_live && pick_vld) begin
          owner_d = pick_idx;
          addr_d  = sel_addr;
          rem_d   = (sel_len > MAX_LEN) ? MAX_LEN : sel_len;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        rr_d = TW'(rrNext(int'(owner_q), NREQ));
        if (!in_live) begin
          abort_d = 1'b1;
          state_d = ST_IDLE;
        end else if (rem_q == '0) begin
          state_d = ST_GAP;
        end else begin
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        addr_d = addr_q + 1'b1;
        rem_d  = rem_q - 1'b1;
        if (!in_live) begin
          abort_d = 1'b1;
          state_d = ST_IDLE;
        end else if (rem_q == LW'(1)) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      abort_q <= abort_d;
    end
  end

  assign owner_oh  = NREQ'(1) << owner_q;
  assign grant     = (state_q == ST_GRANT) ? owner_oh : '0;
  assign done      = (state_q == ST_GAP) ? owner_oh : '0;
  assign abort     = abort_q;
  assign busy      = (state_q != ST_IDLE);
  assign out_rena  = (state_q == ST_BURST);
  assign out_raddr = out_rena ? addr_q : '0;

  // Valid/tag pipeline keeps shifting regardless of FSM state so aborted reads drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_pipe_q[i] <= '0;
    end else begin
      vld_pipe_q[0] <= out_rena;
      tag_pipe_q[0] <= out_rena ? owner_q : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        tag_pipe_q[i] <= tag_pipe_q[i-1];
      end
    end
  end

  assign rd_vld = vld_pipe_q[RD_LAT-1];
  assign rd_tag = tag_pipe_q[RD_LAT-1];

endmodule

// File: tb/tb_et_rd_port_sched.sv
// Self-checking bench for et_rd_port_sched: directed cycle table, multi-cycle corner
// sequences and a randomized run against a transaction-level reference model.
module tb_et_rd_port_sched;

  localparam int DEPTH  = 4096;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inLive = 1'b0;
  logic [2:0]  req = '0;
  logic [35:0] reqAddr = '0;
  logic [38:0] reqLen = '0;
  logic [2:0]  grant, done;
  logic        abort, busy, outRena, rdVld;
  logic [11:0] outRaddr;
  logic [1:0]  rdTag;

  int errCount = 0;
  int checkCount = 0;

  // Reference model: one transaction described by its offset since acceptance.
  bit mAct;
  int mOff, mOwner, mAddr, mLen, mRr;
  bit mAbortPend;
  int hist[$];

  typedef struct {
    logic        live;
    logic [2:0]  rq;
    logic [11:0] addr;
    logic [12:0] len;
    logic [2:0]  eGrant;
    logic [2:0]  eDone;
    logic        eAbort;
    logic        eBusy;
    logic        eRena;
    logic [11:0] eRaddr;
    logic        eVld;
    logic [1:0]  eTag;
  } vec_t;

  vec_t vecs [12];

  et_rd_port_sched dut (
    .clk       (clk),
    .rst       (rst),
    .in_live   (inLive),
    .req       (req),
    .req_addr  (reqAddr),
    .req_len   (reqLen),
    .grant     (grant),
    .done      (done),
    .abort     (abort),
    .busy      (busy),
    .out_rena  (outRena),
    .out_raddr (outRaddr),
    .rd_vld    (rdVld),
    .rd_tag    (rdTag)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [23:0] packOut(input logic [2:0] g, input logic [2:0] d,
                                          input logic a, input logic b, input logic r,
                                          input logic [11:0] ra, input logic v,
                                          input logic [1:0] t);
    return {g, d, a, b, r, ra, v, t};
  endfunction

  function automatic logic [23:0] actualOut();
    return packOut(grant, done, abort, busy, outRena, outRaddr, rdVld, rdTag);
  endfunction

  function automatic logic [23:0] modelExpect();
    logic [2:0]  g, d;
    logic        r;
    logic [11:0] ra;
    g  = (mAct && mOff == 1) ? 3'(1 << mOwner) : 3'b000;
    d  = (mAct && mOff == mLen + 2) ? 3'(1 << mOwner) : 3'b000;
    r  = mAct && mOff >= 2 && mOff <= mLen + 1;
    ra = r ? 12'((mAddr + mOff - 2) % DEPTH) : 12'h000;
    return packOut(g, d, mAbortPend, mAct, r, ra, hist[0][2], hist[0][1:0]);
  endfunction

  function automatic void modelReset();
    mAct = 0; mOff = 0; mOwner = 0; mAddr = 0; mLen = 0; mRr = 0; mAbortPend = 0;
    hist.delete();
    for (int i = 0; i < RD_LAT; i++) hist.push_back(0);
  endfunction

  function automatic void modelUpdate();
    bit rd;
    int pick, l;
    rd = mAct && mOff >= 2 && mOff <= mLen + 1;
    hist.push_back(rd ? (4 + mOwner) : 0);
    void'(hist.pop_front());
    mAbortPend = 0;
    if (mAct) begin
      if (!inLive && mOff <= mLen + 1) begin
        mAbortPend = 1;
        mAct = 0;
      end else if (mOff == mLen + 2) begin
        mAct = 0;
      end else begin
        mOff++;
      end
    end else if (inLive && req != 3'b000) begin
      pick = -1;
      for (int k = 0; k < 3; k++) begin
        int i;
        i = (mRr + k) % 3;
        if (pick < 0 && req[i]) pick = i;
      end
      l      = int'(reqLen[pick*13 +: 13]);
      mAct   = 1;
      mOff   = 1;
      mOwner = pick;
      mAddr  = int'(reqAddr[pick*12 +: 12]);
      mLen   = (l > DEPTH) ? DEPTH : l;
      mRr    = (pick + 1) % 3;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1: check this cycle's outputs, then drive inputs for the next edge.
  task automatic applyStimulus(input logic live, input logic [2:0] rq,
                               input logic [35:0] addrs, input logic [38:0] lens);
    checkOutput("model", 32'(actualOut()), 32'(modelExpect()));
    inLive  = live;
    req     = rq;
    reqAddr = addrs;
    reqLen  = lens;
    modelUpdate();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    req = '0;
    inLive = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 3'b000, '0, '0);
  endtask

  initial begin
    int order[$];
    int nRena, nDone, got;
    logic [11:0] seen[$];
    bit  pend[3];
    logic [11:0] rA[3];
    logic [12:0] rL[3];
    logic [35:0] av;
    logic [38:0] lv;
    logic liveR;

    //              live rq     addr    len    grant  done   ab bs rn raddr   vl tag
    vecs[0]  = '{1'b1, 3'b010, 12'h010, 13'd4, 3'b000, 3'b000, 0, 0, 0, 12'h000, 0, 2'd0};
    vecs[1]  = '{1'b1, 3'b000, 12'h000, 13'd0, 3'b010, 3'b000, 0, 1, 0, 12'h000, 0, 2'd0};
    vecs[2]  = '{1'b1, 3'b000, 12'h000, 13'd0, 3'b000, 3'b000, 0, 1, 1, 12'h010, 0, 2'd0};
    vecs[3]  = '{1'b1, 3'b000, 12'h000, 13'd0, 3'b000, 3'b000, 0, 1, 1, 12'h011, 0, 2'd0};
    vecs[4]  = '{1'b1, 3'b000, 12'h000, 13'd0, 3'b000, 3'b000, 0, 1, 1, 12'h012, 1, 2'd1};
    vecs[5]  = '{1'b1, 3'b000, 12'h000, 13'd0, 3'b000, 3'b000, 0, 1, 1, 12'h013, 1, 2'd1};
    vecs[6]  = '{1'b1, 3'b000, 12'h000, 13'd0, 3'b000, 3'b010, 0, 1, 0, 12'h000, 1, 2'd1};
    vecs[7]  = '{1'b1, 3'b000, 12'h000, 13'd0, 3'b000, 3'b000, 0, 0, 0, 12'h000, 1, 2'd1};
    vecs[8]  = '{1'b1, 3'b100, 12'h555, 13'd0, 3'b000, 3'b000, 0, 0, 0, 12'h000, 0, 2'd0};
    vecs[9]  = '{1'b1, 3'b000, 12'h000, 13'd0, 3'b100, 3'b000, 0, 1, 0, 12'h000, 0, 2'd0};
    vecs[10] = '{1'b1, 3'b000, 12'h000, 13'd0, 3'b000, 3'b100, 0, 1, 0, 12'h000, 0, 2'd0};
    vecs[11] = '{1'b1, 3'b000, 12'h000, 13'd0, 3'b000, 3'b000, 0, 0, 0, 12'h000, 0, 2'd0};

    modelReset();
    applyReset();
    checkOutput("reset_outputs", 32'(actualOut()), 32'h0);

    $display("[TB] single burst and zero-length table");
    for (int k = 0; k < 12; k++) begin
      checkOutput($sformatf("table_row%0d", k), 32'(actualOut()),
                  32'(packOut(vecs[k].eGrant, vecs[k].eDone, vecs[k].eAbort, vecs[k].eBusy,
                              vecs[k].eRena, vecs[k].eRaddr, vecs[k].eVld, vecs[k].eTag)));
      applyStimulus(vecs[k].live, vecs[k].rq, {3{vecs[k].addr}}, {3{vecs[k].len}});
    end
    idleCycles(3);

    $display("[TB] round-robin with all requesters held");
    applyReset();
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      if (grant != 3'b000) begin
        order.push_back(grant == 3'b001 ? 0 : grant == 3'b010 ? 1 : grant == 3'b100 ? 2 : 9);
        got++;
      end
      applyStimulus(1'b1, 3'b111, {12'h300, 12'h200, 12'h100}, {3{13'd2}});
    end
    checkOutput("rr_grant_count", 32'(got), 32'd4);
    for (int i = 0; i < order.size(); i++)
      checkOutput($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 3));
    idleCycles(8);

    $display("[TB] address wrap");
    applyStimulus(1'b1, 3'b001, {3{12'hFFE}}, {3{13'd4}});
    nDone = 0;
    for (int c = 0; c < 10; c++) begin
      if (outRena) seen.push_back(outRaddr);
      if (done != 3'b000) nDone++;
      applyStimulus(1'b1, 3'b000, '0, '0);
    end
    checkOutput("wrap_reads", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) begin
      checkOutput("wrap_a0", 32'(seen[0]), 32'hFFE);
      checkOutput("wrap_a1", 32'(seen[1]), 32'hFFF);
      checkOutput("wrap_a2", 32'(seen[2]), 32'h000);
      checkOutput("wrap_a3", 32'(seen[3]), 32'h001);
    end
    checkOutput("wrap_done_count", 32'(nDone), 32'd1);

    $display("[TB] run window drop mid-burst");
    applyStimulus(1'b1, 3'b010, {3{12'h100}}, {3{13'd8}});
    applyStimulus(1'b1, 3'b000, '0, '0);
    applyStimulus(1'b1, 3'b000, '0, '0);
    applyStimulus(1'b1, 3'b000, '0, '0);
    applyStimulus(1'b0, 3'b010, {3{12'h100}}, {3{13'd8}});
    checkOutput("live_abort", 32'(abort), 32'd1);
    checkOutput("live_rena_off", 32'(outRena), 32'd0);
    checkOutput("live_no_done", 32'(done), 32'd0);
    checkOutput("live_drain1", 32'(rdVld), 32'd1);
    applyStimulus(1'b0, 3'b010, {3{12'h100}}, {3{13'd8}});
    checkOutput("live_drain2", 32'(rdVld), 32'd1);
    checkOutput("live_abort_once", 32'(abort), 32'd0);
    applyStimulus(1'b0, 3'b010, {3{12'h100}}, {3{13'd8}});
    checkOutput("live_drained", 32'(rdVld), 32'd0);
    applyStimulus(1'b0, 3'b010, {3{12'h100}}, {3{13'd8}});
    checkOutput("live_blocked", 32'({busy, grant}), 32'd0);
    applyStimulus(1'b1, 3'b010, {3{12'h100}}, {3{13'd8}});
    checkOutput("live_resume_grant", 32'(grant), 32'b010);
    idleCycles(12);

    $display("[TB] length clamp");
    applyStimulus(1'b1, 3'b001, {3{12'h123}}, {3{13'd5000}});
    nRena = 0;
    nDone = 0;
    for (int c = 0; c < 4300 && nDone == 0; c++) begin
      if (outRena) nRena++;
      if (done == 3'b001) nDone++;
      applyStimulus(1'b1, 3'b000, '0, '0);
    end
    checkOutput("clamp_done_seen", 32'(nDone), 32'd1);
    checkOutput("clamp_reads", 32'(nRena), 32'(DEPTH));
    idleCycles(4);

    $display("[TB] async reset mid-burst");
    applyStimulus(1'b1, 3'b010, {3{12'h050}}, {3{13'd8}});
    applyStimulus(1'b1, 3'b000, '0, '0);
    applyStimulus(1'b1, 3'b000, '0, '0);
    applyStimulus(1'b1, 3'b000, '0, '0);
    checkOutput("pre_reset_rena", 32'(outRena), 32'd1);
    #2 rst = 1'b1;
    #1 checkOutput("async_reset_outputs", 32'(actualOut()), 32'h0);
    #2 rst = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 3'b111, {3{12'h040}}, {3{13'd1}});
    checkOutput("post_reset_rr0", 32'(grant), 32'b001);
    idleCycles(6);

    $display("[TB] randomized run against reference model");
    for (int i = 0; i < 3; i++) begin
      pend[i] = 0;
      rA[i] = '0;
      rL[i] = '0;
    end
    liveR = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      if (mAct && mOff == 1) pend[mOwner] = 0;
      for (int i = 0; i < 3; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 99) < 20) begin
            pend[i] = 1;
            rA[i] = ($urandom_range(0, 3) == 0) ? 12'(12'hFF8 + $urandom_range(0, 7))
                                                : 12'($urandom);
            rL[i] = 13'($urandom_range(0, 9));
          end
        end else if ($urandom_range(0, 99) < 2) begin
          pend[i] = 0;
        end
      end
      if (liveR && $urandom_range(0, 99) < 3) liveR = 1'b0;
      else if (!liveR && $urandom_range(0, 99) < 30) liveR = 1'b1;
      for (int i = 0; i < 3; i++) begin
        av[i*12 +: 12] = rA[i];
        lv[i*13 +: 13] = rL[i];
      end
      applyStimulus(liveR, {pend[2], pend[1], pend[0]}, av, lv);
    end
    idleCycles(12);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
